// File: rtl/pulse_gen_pkg.sv
// Shared types and default widths for the delayed pulse generator.
package pulse_gen_pkg;

  localparam int unsigned CNT_WIDTH_DEF  = 16;
  localparam int unsigned STAT_WIDTH_DEF = 32;

  // Sequencer phases; IDLE must stay the reset encoding.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DELAY = 2'd1,
    ST_PULSE = 2'd2
  } pg_state_e;

endpackage : pulse_gen_pkg

// File: rtl/load_down_counter.sv
// Loadable down-counter with a terminal-count flag.
//   clk, rst_n   : clock, async active-low reset
//   load_i       : load load_val_i this cycle (wins over dec_i)
//   load_val_i   : value to load
//   dec_i        : decrement by one (holds at zero)
//   count_o      : current count (registered)
//   expired_c_o  : combinational flag, count is zero
module load_down_counter #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic             dec_i,
  output logic [WIDTH-1:0] count_o,
  output logic             expired_c_o
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  // Next count: load has priority, decrement never underflows.
  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (dec_i && (count_q != '0)) begin
      count_d = count_q - WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o     = count_q;
  assign expired_c_o = (count_q == '0);

endmodule : load_down_counter

// File: rtl/delayed_pulse_gen.sv
// Delayed pulse generator: a sampled trigger produces a pulse_out of `width`
// cycles starting `delay`+1 cycles later; keeps accepted/missed trigger counts.
//   clk, rst_n    : clock, async active-low reset
//   enable        : low forces idle and ignores triggers
//   trig_pulse    : trigger from the edge detector
//   retrigger     : 1 restarts a running sequence, 0 drops and counts it
//   delay, width  : timing, captured when a trigger is accepted
//   clear_counts  : synchronous clear of the statistic counters
//   pulse_out     : registered output pulse
//   busy          : registered, sequence in progress
//   trig_count    : accepted triggers (wrapping)
//   missed_count  : triggers dropped while busy (wrapping)
module delayed_pulse_gen
  import pulse_gen_pkg::*;
#(
  parameter int unsigned CNT_WIDTH  = CNT_WIDTH_DEF,
  parameter int unsigned STAT_WIDTH = STAT_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic                  trig_pulse,
  input  logic                  retrigger,
  input  logic [CNT_WIDTH-1:0]  delay,
  input  logic [CNT_WIDTH-1:0]  width,
  input  logic                  clear_counts,
  output logic                  pulse_out,
  output logic                  busy,
  output logic [STAT_WIDTH-1:0] trig_count,
  output logic [STAT_WIDTH-1:0] missed_count
);

  pg_state_e             state_q, state_d;
  logic [CNT_WIDTH-1:0]  width_q, width_d;
  logic                  pulse_q, pulse_d;
  logic                  busy_q, busy_d;
  logic [STAT_WIDTH-1:0] trig_cnt_q, trig_cnt_d;
  logic [STAT_WIDTH-1:0] miss_cnt_q, miss_cnt_d;

  logic                  cnt_load;
  logic [CNT_WIDTH-1:0]  cnt_load_val;
  logic                  cnt_dec;
  logic [CNT_WIDTH-1:0]  cnt_value;
  logic                  cnt_expired;

  logic                  accept;
  logic                  missed;

  // One counter times both phases; it is loaded with (cycles - 1).
  load_down_counter #(
    .WIDTH (CNT_WIDTH)
  ) u_cnt (
    .clk         (clk),
    .rst_n       (rst_n),
    .load_i      (cnt_load),
    .load_val_i  (cnt_load_val),
    .dec_i       (cnt_dec),
    .count_o     (cnt_value),
    .expired_c_o (cnt_expired)
  );

  assign accept = enable && trig_pulse && ((state_q == ST_IDLE) || retrigger);
  assign missed = enable && trig_pulse && (state_q != ST_IDLE) && !retrigger;

  // Next-state, counter control and output decode.
  always_comb begin
    state_d      = state_q;
    width_d      = width_q;
    cnt_load     = 1'b0;
    cnt_load_val = '0;
    cnt_dec      = 1'b0;
    trig_cnt_d   = trig_cnt_q;
    miss_cnt_d   = miss_cnt_q;

    if (!enable) begin
      state_d = ST_IDLE;
    end else if (accept) begin
      // Delay is consumed by the counter load; only width is needed later.
      width_d = width;
      if (width == '0) begin
        state_d = ST_IDLE;
      end else if (delay == '0) begin
        state_d      = ST_PULSE;
        cnt_load     = 1'b1;
        cnt_load_val = width - CNT_WIDTH'(1);
      end else begin
        state_d      = ST_DELAY;
        cnt_load     = 1'b1;
        cnt_load_val = delay - CNT_WIDTH'(1);
      end
    end else begin
      unique case (state_q)
        ST_DELAY: begin
          if (cnt_expired) begin
            state_d      = ST_PULSE;
            cnt_load     = 1'b1;
            cnt_load_val = width_q - CNT_WIDTH'(1);
          end else begin
            cnt_dec = 1'b1;
          end
        end
        ST_PULSE: begin
          if (cnt_expired) begin
            state_d = ST_IDLE;
          end else begin
            cnt_dec = 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    // Outputs are a registered decode of the current state; enable low
    // drops them on the very next edge.
    pulse_d = enable && (state_q == ST_PULSE);
    busy_d  = enable && (state_q != ST_IDLE);

    if (clear_counts) begin
      trig_cnt_d = '0;
      miss_cnt_d = '0;
    end else begin
      if (accept) trig_cnt_d = trig_cnt_q + STAT_WIDTH'(1);
      if (missed) miss_cnt_d = miss_cnt_q + STAT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      width_q    <= '0;
      pulse_q    <= 1'b0;
      busy_q     <= 1'b0;
      trig_cnt_q <= '0;
      miss_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      width_q    <= width_d;
      pulse_q    <= pulse_d;
      busy_q     <= busy_d;
      trig_cnt_q <= trig_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign pulse_out    = pulse_q;
  assign busy         = busy_q;
  assign trig_count   = trig_cnt_q;
  assign missed_count = miss_cnt_q;

  // Count value is only consumed through the expiry flag.
  logic unused_cnt;
  assign unused_cnt = ^cnt_value;

endmodule : delayed_pulse_gen
